// File: rtl/processador_pkg.sv
// Shared definitions for the processor control side: wait-controller
// state encoding and the default time-base constants.
package processador_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        FIM      = 2'd2
    } estado_espera_t;

    localparam int DIV_MS     = 50000;
    localparam int LARG_TEMPO = 32;

endpackage

// File: rtl/controle_espera_divisor_ms.sv
// Millisecond time base: prescaler that produces a one-cycle tick every
// DIV clocks, plus the free-running millisecond counter it advances.
module divisor_ms
    import processador_pkg::*;
#(
    parameter int DIV = DIV_MS,
    parameter int W   = LARG_TEMPO
) (
    input  logic         clk,
    input  logic         reset,
    output logic         tick,
    output logic [W-1:0] tempo
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= '0;
            tempo <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            // wraps modulo 2^W silently
            if (tick)
                tempo <= tempo + W'(1);
        end
    end

endmodule

// File: rtl/controle_espera.sv
// Millisecond wait controller: stalls the core for a programmed number of
// milliseconds and pulses fim once when the wait completes normally.
module controle_espera
    import processador_pkg::*;
#(
    parameter int DIV = DIV_MS,
    parameter int W   = LARG_TEMPO
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inicio,
    input  logic [W-1:0] periodo,
    input  logic         cancela,
    output logic         espera,
    output logic         fim,
    output logic [W-1:0] restante,
    output logic [W-1:0] tempo
);

    estado_espera_t estado;
    logic           tick;

    divisor_ms #(
        .DIV (DIV),
        .W   (W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .tempo (tempo)
    );

    // espera and fim are registered mirrors of the next state
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado   <= OCIOSO;
            restante <= '0;
            espera   <= 1'b0;
            fim      <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (inicio && !cancela) begin
                        if (periodo != '0) begin
                            estado   <= CONTANDO;
                            restante <= periodo;
                            espera   <= 1'b1;
                        end else begin
                            estado <= FIM;
                            fim    <= 1'b1;
                        end
                    end
                end
                CONTANDO: begin
                    if (cancela) begin
                        estado   <= OCIOSO;
                        restante <= '0;
                        espera   <= 1'b0;
                    end else if (tick) begin
                        restante <= restante - W'(1);
                        if (restante == W'(1)) begin
                            estado <= FIM;
                            espera <= 1'b0;
                            fim    <= 1'b1;
                        end
                    end
                end
                FIM: begin
                    estado <= OCIOSO;
                    fim    <= 1'b0;
                end
                default: begin
                    estado   <= OCIOSO;
                    restante <= '0;
                    espera   <= 1'b0;
                    fim      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_espera.sv
// Directed bench for controle_espera with a 4-cycle millisecond divider.
module tb_controle_espera;

    localparam int DIV = 4;
    localparam int W   = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         inicio;
    logic [W-1:0] periodo;
    logic         cancela;
    logic         espera;
    logic         fim;
    logic [W-1:0] restante;
    logic [W-1:0] tempo;

    int checks   = 0;
    int failures = 0;

    // bench-side model of the prescaler phase and the ms counter
    int           ph = 0;
    logic [W-1:0] exp_tempo = '0;

    controle_espera #(
        .DIV (DIV),
        .W   (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .inicio   (inicio),
        .periodo  (periodo),
        .cancela  (cancela),
        .espera   (espera),
        .fim      (fim),
        .restante (restante),
        .tempo    (tempo)
    );

    always #5 clk = ~clk;

    task automatic step();
        if (!reset) begin
            ph        = 0;
            exp_tempo = '0;
        end else begin
            if (ph == DIV - 1)
                exp_tempo = exp_tempo + 1;
            ph = (ph + 1) % DIV;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0;
        step();
        step();
        checks++;
        if (espera !== 1'b0 || fim !== 1'b0 || restante !== '0 || tempo !== '0) begin
            failures++;
            $display("FAIL reset_values espera=%b fim=%b restante=%0d tempo=%0d expected 0 0 0 0",
                     espera, fim, restante, tempo);
        end
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (espera !== 1'b0 || fim !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_outputs cycles_with_espera_or_fim=%0d expected 0", bad);
        end
        checks++;
        if (tempo !== 32'd10) begin
            failures++;
            $display("FAIL idle_tempo got=%0d expected 10", tempo);
        end
    endtask

    task automatic test_periodo3();
        int n_esp;
        int n_fim;
        int fim_at;
        logic [W-1:0] exp_r;
        if (ph != 0) begin
            checks++;
            failures++;
            $display("FAIL p3_phase got=%0d expected 0", ph);
        end
        inicio  = 1'b1;
        periodo = 32'd3;
        step();
        inicio = 1'b0;
        n_esp  = 0;
        n_fim  = 0;
        fim_at = -1;
        for (int i = 0; i < 20; i++) begin
            if (espera === 1'b1) n_esp++;
            if (fim === 1'b1) begin
                n_fim++;
                fim_at = i;
            end
            if (i == 0 || i == 3 || i == 7 || i == 11) begin
                exp_r = (i == 0) ? 32'd3 : (i == 3) ? 32'd2 : (i == 7) ? 32'd1 : 32'd0;
                checks++;
                if (restante !== exp_r) begin
                    failures++;
                    $display("FAIL p3_restante sample=%0d got=%0d expected %0d", i, restante, exp_r);
                end
            end
            step();
        end
        checks++;
        if (n_esp != 11) begin
            failures++;
            $display("FAIL p3_espera_cycles got=%0d expected 11", n_esp);
        end
        checks++;
        if (n_fim != 1 || fim_at != 11) begin
            failures++;
            $display("FAIL p3_fim count=%0d at=%0d expected 1 at 11", n_fim, fim_at);
        end
        checks++;
        if (espera !== 1'b0 || fim !== 1'b0 || tempo !== exp_tempo) begin
            failures++;
            $display("FAIL p3_after espera=%b fim=%b tempo=%0d expected 0 0 %0d",
                     espera, fim, tempo, exp_tempo);
        end
    endtask

    task automatic test_periodo0();
        inicio  = 1'b1;
        periodo = 32'd0;
        step();
        inicio = 1'b0;
        checks++;
        if (fim !== 1'b1 || espera !== 1'b0 || restante !== '0) begin
            failures++;
            $display("FAIL p0_first fim=%b espera=%b restante=%0d expected 1 0 0", fim, espera, restante);
        end
        step();
        checks++;
        if (fim !== 1'b0 || espera !== 1'b0) begin
            failures++;
            $display("FAIL p0_second fim=%b espera=%b expected 0 0", fim, espera);
        end
    endtask

    task automatic test_cancela();
        int nt;
        int n_fim;
        bit done;
        inicio  = 1'b1;
        periodo = 32'd5;
        step();
        inicio = 1'b0;
        nt   = 0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (ph == DIV - 1) begin
                if (nt == 1) begin
                    checks++;
                    if (restante !== 32'd4) begin
                        failures++;
                        $display("FAIL cancel_before got=%0d expected 4", restante);
                    end
                    cancela = 1'b1;
                    step();
                    cancela = 1'b0;
                    done = 1;
                end else begin
                    step();
                    nt++;
                end
            end else begin
                step();
            end
        end
        checks++;
        if (espera !== 1'b0 || restante !== '0 || fim !== 1'b0) begin
            failures++;
            $display("FAIL cancel_after espera=%b restante=%0d fim=%b expected 0 0 0",
                     espera, restante, fim);
        end
        n_fim = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (fim === 1'b1 || espera === 1'b1) n_fim++;
        end
        checks++;
        if (n_fim != 0) begin
            failures++;
            $display("FAIL cancel_quiet cycles_active=%0d expected 0", n_fim);
        end
    endtask

    task automatic test_wrap();
        int nt;
        int n_fim;
        bit saw_zero;
        force dut.u_div.tempo = 32'hFFFF_FFFE;
        #1;
        release dut.u_div.tempo;
        exp_tempo = 32'hFFFF_FFFE;
        inicio  = 1'b1;
        periodo = 32'd4;
        step();
        inicio   = 1'b0;
        nt       = 0;
        n_fim    = 0;
        saw_zero = 0;
        for (int i = 0; i < 30; i++) begin
            if (espera === 1'b1 && ph == DIV - 1) nt++;
            step();
            if (tempo === '0) saw_zero = 1;
            if (fim === 1'b1) n_fim++;
        end
        checks++;
        if (!saw_zero || tempo !== exp_tempo) begin
            failures++;
            $display("FAIL wrap_tempo saw_zero=%0d got=%0d expected %0d", saw_zero, tempo, exp_tempo);
        end
        checks++;
        if (nt != 4 || n_fim != 1) begin
            failures++;
            $display("FAIL wrap_wait ticks=%0d fims=%0d expected 4 1", nt, n_fim);
        end
    endtask

    task automatic test_inicio_reset_mid();
        int guard;
        inicio  = 1'b1;
        periodo = 32'd3;
        step();
        inicio  = 1'b0;
        guard   = 0;
        while (restante !== 32'd2 && guard < 20) begin
            step();
            guard++;
        end
        checks++;
        if (restante !== 32'd2 || espera !== 1'b1) begin
            failures++;
            $display("FAIL mid_reach restante=%0d espera=%b expected 2 1", restante, espera);
        end
        // just after a tick, so the next edge carries no tick
        inicio  = 1'b1;
        periodo = 32'd7;
        step();
        inicio  = 1'b0;
        checks++;
        if (restante !== 32'd2 || espera !== 1'b1) begin
            failures++;
            $display("FAIL busy_inicio restante=%0d espera=%b expected 2 1", restante, espera);
        end
        reset = 1'b0;
        step();
        checks++;
        if (espera !== 1'b0 || fim !== 1'b0 || restante !== '0 || tempo !== '0) begin
            failures++;
            $display("FAIL mid_reset espera=%b fim=%b restante=%0d tempo=%0d expected 0 0 0 0",
                     espera, fim, restante, tempo);
        end
        reset = 1'b1;
        guard = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (fim === 1'b1 || espera === 1'b1) guard++;
        end
        checks++;
        if (guard != 0 || tempo !== exp_tempo) begin
            failures++;
            $display("FAIL post_reset active=%0d tempo=%0d expected 0 %0d", guard, tempo, exp_tempo);
        end
    endtask

    initial begin
        reset   = 1'b0;
        inicio  = 1'b0;
        periodo = '0;
        cancela = 1'b0;
        @(negedge clk);
        test_reset();
        test_periodo3();
        test_periodo0();
        test_cancela();
        test_wrap();
        test_inicio_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
